// File: rtl/dma_desc_fetch_if.sv
// Bus bundle for the descriptor fetcher: AXI read address/data channels plus
// the field-write port into the DMA descriptor register block.
interface dma_desc_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [7:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARVALID;
   logic              ARREADY;

   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;

   logic [DATA_W-1:0] DESC_input;
   logic [3:0]        DESC_sel;
   logic              DESC_write_en;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY,
      output DESC_input, DESC_sel, DESC_write_en
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY,
      input  DESC_input, DESC_sel, DESC_write_en
   );
endinterface

// File: rtl/dma_desc_fetch.sv
// Walks a linked list of 5-word DMA descriptors over AXI, loads each field into
// the descriptor register block, starts the engine and follows NEXT_DESC until EOC.
//
// state  | meaning
// IDLE   | waiting for DMAEN
// AR     | read address presented at ptr
// RD     | accepting the 5 descriptor beats
// START  | beat-4 field write in flight; start pulse issued on exit
// WAIT   | engine running, waiting for Done
// FINISH | chain complete, parked until DMAEN drops
// ERR    | bus/protocol error, parked until DMAEN drops
module dma_desc_fetch #(
   parameter int              ADDR_W = 32,
   parameter int              DATA_W = 32,
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] MST_ID = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DMAEN,
   input  logic [ADDR_W-1:0] DESC_BASE,
   input  logic              Done,
   dma_desc_fetch_if.master  bus,
   output logic              engine_start,
   output logic              busy,
   output logic              chain_done,
   output logic              err
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] AR     = 3'd1;
   localparam logic [2:0] RD     = 3'd2;
   localparam logic [2:0] START  = 3'd3;
   localparam logic [2:0] WAIT   = 3'd4;
   localparam logic [2:0] FINISH = 3'd5;
   localparam logic [2:0] ERR    = 3'd6;

   logic [2:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] next_ptr;
   logic [2:0]        beat;
   logic              eoc;
   logic              desc_we;
   logic [3:0]        desc_sel;
   logic [DATA_W-1:0] desc_data;
   logic              beat_hs;
   logic              beat_fault;
   logic              unused_ok;

   assign bus.ARID          = MST_ID;
   assign bus.ARADDR        = ptr;
   assign bus.ARLEN         = 8'd4;
   assign bus.ARSIZE        = 3'b010;
   assign bus.ARBURST       = 2'b01;
   assign bus.ARVALID       = (state == AR);
   assign bus.RREADY        = (state == RD);
   assign bus.DESC_input    = desc_data;
   assign bus.DESC_sel      = desc_sel;
   assign bus.DESC_write_en = desc_we;
   assign busy              = (state != IDLE);

   assign unused_ok = ^{bus.RID, DESC_BASE[4:0]};

   assign beat_hs    = bus.RVALID & bus.RREADY;
   // A short burst, an overlong burst or a non-OKAY response all poison the descriptor.
   assign beat_fault = (bus.RRESP != 2'b00)
                     | (bus.RLAST & (beat != 3'd4))
                     | ((beat == 3'd4) & ~bus.RLAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         next_ptr     <= '0;
         beat         <= '0;
         eoc          <= 1'b0;
         desc_we      <= 1'b0;
         desc_sel     <= '0;
         desc_data    <= '0;
         engine_start <= 1'b0;
         chain_done   <= 1'b0;
         err          <= 1'b0;
      end else begin
         desc_we      <= 1'b0;
         engine_start <= 1'b0;
         chain_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (DMAEN) begin
                  ptr   <= {DESC_BASE[ADDR_W-1:5], 5'b0};
                  state <= AR;
               end
            end
            AR: begin
               if (bus.ARREADY) begin
                  beat  <= '0;
                  state <= RD;
               end
            end
            RD: begin
               if (beat_hs) begin
                  beat <= beat + 3'd1;
                  if (!err && !beat_fault) begin
                     desc_we   <= 1'b1;
                     desc_sel  <= {1'b0, beat};
                     desc_data <= bus.RDATA;
                     if (beat == 3'd3) next_ptr <= {bus.RDATA[ADDR_W-1:5], 5'b0};
                     if (beat == 3'd4) eoc <= bus.RDATA[0];
                  end else begin
                     err <= 1'b1;
                  end
                  // Once poisoned, keep draining until the interconnect closes the burst.
                  if (bus.RLAST) state <= (err || beat_fault) ? ERR : START;
               end
            end
            START: begin
               engine_start <= 1'b1;
               state        <= WAIT;
            end
            WAIT: begin
               if (Done) begin
                  if (eoc) begin
                     chain_done <= 1'b1;
                     state      <= FINISH;
                  end else begin
                     ptr   <= next_ptr;
                     state <= AR;
                  end
               end
            end
            FINISH: begin
               if (!DMAEN) state <= IDLE;
            end
            ERR: begin
               if (!DMAEN) begin
                  err   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_desc_fetch.sv
// Self-checking bench for dma_desc_fetch: AXI memory responder, Done responder,
// scoreboard queues for AR addresses and descriptor field writes.
module tb_dma_desc_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        DMAEN;
   logic        Done;
   logic [31:0] DESC_BASE;
   logic        engine_start, busy, chain_done, err;

   dma_desc_fetch_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

   dma_desc_fetch #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MST_ID(4'd0)) dut (
      .clk(clk), .rst(rst), .DMAEN(DMAEN), .DESC_BASE(DESC_BASE), .Done(Done),
      .bus(bus), .engine_start(engine_start), .busy(busy),
      .chain_done(chain_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      base;
      logic [4:0][31:0] w;
      int               ar_dly;
      int               gap;
      int               err_beat;
      logic [31:0]      exp_addr;
      int               exp_writes;
      int               exp_starts;
      logic             exp_err;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] mem [logic [31:0]];
   logic [35:0] exp_desc [$];
   logic [31:0] exp_ar [$];
   int          ar_stamps [$];
   int          done_stamps [$];

   int n_cmp = 0, n_bad = 0;
   int n_starts = 0, n_chain = 0, ncyc = 0;
   int done_cnt = -1, done_dly = 3;
   bit spur_req = 1'b0;
   int sphase = 0, s_cnt = 0, s_beat = 0, s_ardly = 0, s_gap = 0, s_errbeat = -1;
   logic [31:0] s_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h, required %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] base, input logic [31:0] w0, w1, w2, w3, w4,
                               input int ar_dly, gap, err_beat, input logic [31:0] exp_addr,
                               input int exp_writes, exp_starts, input logic exp_err);
      vec_t v;
      v.base = base;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
      v.ar_dly = ar_dly; v.gap = gap; v.err_beat = err_beat;
      v.exp_addr = exp_addr; v.exp_writes = exp_writes;
      v.exp_starts = exp_starts; v.exp_err = exp_err;
      return v;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
   endfunction

   task automatic drive_beat();
      bus.RVALID = 1'b1;
      bus.RDATA  = mem_rd(s_addr + 32'(4 * s_beat));
      bus.RLAST  = (s_beat == 4);
      bus.RRESP  = (s_beat == s_errbeat) ? 2'b10 : 2'b00;
      chk("rready_held", {63'd0, bus.RREADY}, 64'd1);
   endtask

   task automatic load_desc(input logic [31:0] addr, input logic [4:0][31:0] w, input int nwr);
      for (int i = 0; i < 5; i++) mem[addr + 32'(4 * i)] = w[i];
      for (int i = 0; i < nwr; i++) exp_desc.push_back({4'(i), w[i]});
   endtask

   task automatic wait_end(input int chain0, input string name);
      int k = 0;
      while (k < 400 && n_chain == chain0 && !err) begin
         @(negedge clk);
         k++;
      end
      chk(name, {63'd0, k < 400}, 64'd1);
   endtask

   task automatic drop_en();
      DMAEN = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_err", {63'd0, err}, 64'd0);
      exp_desc.delete();
      exp_ar.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int st0, ch0;
      load_desc(v.exp_addr, v.w, v.exp_writes);
      exp_ar.push_back(v.exp_addr);
      s_ardly = v.ar_dly; s_gap = v.gap; s_errbeat = v.err_beat;
      st0 = n_starts; ch0 = n_chain;
      @(negedge clk);
      DESC_BASE = v.base;
      DMAEN     = 1'b1;
      wait_end(ch0, "vec_complete");
      repeat (20) @(negedge clk);
      chk("starts", 64'(n_starts - st0), 64'(v.exp_starts));
      chk("chain_done", 64'(n_chain - ch0), v.exp_err ? 64'd0 : 64'd1);
      chk("err", {63'd0, err}, {63'd0, v.exp_err});
      chk("busy_hold", {63'd0, busy}, 64'd1);
      chk("desc_left", 64'(exp_desc.size()), 64'd0);
      chk("ar_left", 64'(exp_ar.size()), 64'd0);
      drop_en();
   endtask

   initial begin
      rst = 1'b1; DMAEN = 1'b0; Done = 1'b0; DESC_BASE = '0;
      bus.ARREADY = 1'b0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0;
      bus.RLAST = 1'b0; bus.RVALID = 1'b0;
      vecs[0] = mk(32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h0, 32'h1, 0, 0, -1, 32'h1000, 5, 1, 1'b0);
      vecs[1] = mk(32'h1100, 32'hA0, 32'hB0, 32'hC0, 32'h0, 32'h1, 3, 2, -1, 32'h1100, 5, 1, 1'b0);
      vecs[2] = mk(32'h1200, 32'h12, 32'h34, 32'h56, 32'h78, 32'h1, 0, 0, 2, 32'h1200, 2, 0, 1'b1);
      vecs[3] = mk(32'h1014, 32'h5000, 32'h6000, 32'h80, 32'h0, 32'h1, 0, 0, -1, 32'h1000, 5, 1, 1'b0);
      vecs[4] = mk(32'h1340, 32'h9, 32'h8, 32'h7, 32'h6, 32'h1, 2, 1, 0, 32'h1340, 0, 0, 1'b1);
      vecs[5] = mk(32'h1380, 32'h1, 32'h2, 32'h3, 32'h4, 32'h1, 1, 0, 4, 32'h1380, 4, 0, 1'b1);
      fork
         begin : responder
            logic [35:0] e;
            forever begin
               @(negedge clk);
               ncyc++;
               Done = 1'b0;
               if (rst) begin
                  sphase = 0; done_cnt = -1;
                  bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
               end else begin
                  if (bus.DESC_write_en) begin
                     if (exp_desc.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL desc_unexpected: actual sel=%0d data=%0h, required no write",
                                 bus.DESC_sel, bus.DESC_input);
                     end else begin
                        e = exp_desc.pop_front();
                        chk("desc_write", {28'd0, bus.DESC_sel, bus.DESC_input}, {28'd0, e});
                     end
                  end
                  if (chain_done) n_chain++;
                  if (done_cnt > 0) begin
                     done_cnt--;
                     if (done_cnt == 0) begin
                        Done = 1'b1;
                        done_stamps.push_back(ncyc);
                        done_cnt = -1;
                     end
                  end
                  if (engine_start) begin
                     n_starts++;
                     done_cnt = done_dly;
                  end
                  if (spur_req) begin
                     Done = 1'b1;
                     spur_req = 1'b0;
                  end
                  case (sphase)
                     0: begin
                        bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
                        if (bus.ARVALID) begin
                           ar_stamps.push_back(ncyc);
                           s_addr = bus.ARADDR;
                           if (exp_ar.size() == 0) begin
                              n_cmp++; n_bad++;
                              $display("FAIL ar_unexpected: actual %0h, required no request", bus.ARADDR);
                           end else begin
                              chk("araddr", {32'd0, bus.ARADDR}, {32'd0, exp_ar.pop_front()});
                           end
                           chk("ar_const", {47'd0, bus.ARID, bus.ARLEN, bus.ARSIZE, bus.ARBURST},
                               {47'd0, 4'd0, 8'd4, 3'b010, 2'b01});
                           s_cnt = s_ardly;
                           if (s_cnt == 0) begin
                              bus.ARREADY = 1'b1;
                              sphase = 1;
                           end else begin
                              sphase = 3;
                           end
                        end
                     end
                     3: begin
                        chk("ar_stable", {31'd0, bus.ARVALID, bus.ARADDR}, {31'd0, 1'b1, s_addr});
                        s_cnt--;
                        if (s_cnt == 0) begin
                           bus.ARREADY = 1'b1;
                           sphase = 1;
                        end
                     end
                     1: begin
                        bus.ARREADY = 1'b0;
                        chk("arvalid_drop", {63'd0, bus.ARVALID}, 64'd0);
                        s_beat = 0;
                        drive_beat();
                        sphase = 2;
                     end
                     default: begin
                        if (bus.RVALID) begin
                           if (bus.RLAST) begin
                              bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
                              sphase = 0;
                           end else begin
                              s_beat++;
                              if (s_gap > 0) begin
                                 bus.RVALID = 1'b0;
                                 s_cnt = s_gap;
                              end else begin
                                 drive_beat();
                              end
                           end
                        end else begin
                           s_cnt--;
                           if (s_cnt == 0) drive_beat();
                        end
                     end
                  endcase
               end
            end
         end
         begin : main
            int k, st0, ch0;
            logic [4:0][31:0] wa, wb;
            repeat (3) @(negedge clk);
            chk("rst_ctrl", {57'd0, bus.ARVALID, bus.RREADY, bus.DESC_write_en, engine_start,
                             busy, chain_done, err}, 64'd0);
            chk("rst_desc", {28'd0, bus.DESC_sel, bus.DESC_input}, 64'd0);
            chk("rst_addr", {32'd0, bus.ARADDR}, 64'd0);
            rst = 1'b0;
            repeat (2) @(negedge clk);

            for (int i = 0; i < 6; i++) run_vec(vecs[i]);

            // Spurious Done while idle must not wake the fetcher.
            spur_req = 1'b1;
            repeat (4) @(negedge clk);
            chk("spur_idle", {62'd0, busy, bus.ARVALID}, 64'd0);

            // Two-link chain; NEXT_DESC carries low bits that must be dropped.
            wa[0] = 32'h11; wa[1] = 32'h22; wa[2] = 32'h33; wa[3] = 32'h1027; wa[4] = 32'h0;
            wb[0] = 32'h44; wb[1] = 32'h55; wb[2] = 32'h66; wb[3] = 32'h0;    wb[4] = 32'h1;
            load_desc(32'h1000, wa, 5);
            load_desc(32'h1020, wb, 5);
            exp_ar.push_back(32'h1000);
            exp_ar.push_back(32'h1020);
            s_ardly = 0; s_gap = 0; s_errbeat = -1;
            ar_stamps.delete(); done_stamps.delete();
            st0 = n_starts; ch0 = n_chain;
            @(negedge clk);
            DESC_BASE = 32'h1000; DMAEN = 1'b1;
            wait_end(ch0, "chain_complete");
            repeat (10) @(negedge clk);
            chk("chain_starts", 64'(n_starts - st0), 64'd2);
            chk("chain_dones", 64'(n_chain - ch0), 64'd1);
            chk("chain_desc_left", 64'(exp_desc.size()), 64'd0);
            if (ar_stamps.size() >= 2 && done_stamps.size() >= 1)
               chk("ar_after_done", 64'(ar_stamps[1] - done_stamps[0]), 64'd1);
            else
               chk("chain_ar_count", 64'(ar_stamps.size()), 64'd2);
            drop_en();

            // Reset in the middle of the burst, then a clean restart from DESC_BASE.
            load_desc(32'h1000, vecs[0].w, 2);
            exp_ar.push_back(32'h1000);
            @(negedge clk);
            DESC_BASE = 32'h1000; DMAEN = 1'b1;
            k = 0;
            while (k < 100 && !(bus.DESC_write_en && bus.DESC_sel == 4'd1)) begin
               @(negedge clk);
               k++;
            end
            chk("rst_reach_beat2", {63'd0, k < 100}, 64'd1);
            #2 rst = 1'b1;
            #1;
            chk("midrst_ctrl", {57'd0, bus.ARVALID, bus.RREADY, bus.DESC_write_en, engine_start,
                                busy, chain_done, err}, 64'd0);
            chk("midrst_desc", {28'd0, bus.DESC_sel, bus.DESC_input}, 64'd0);
            chk("midrst_addr", {32'd0, bus.ARADDR}, 64'd0);
            @(negedge clk);
            chk("midrst_left", 64'(exp_desc.size()), 64'd0);
            exp_desc.delete();
            exp_ar.delete();
            load_desc(32'h1000, vecs[0].w, 5);
            exp_ar.push_back(32'h1000);
            repeat (2) @(negedge clk);
            st0 = n_starts; ch0 = n_chain;
            rst = 1'b0;
            wait_end(ch0, "restart_complete");
            repeat (10) @(negedge clk);
            chk("restart_starts", 64'(n_starts - st0), 64'd1);
            chk("restart_dones", 64'(n_chain - ch0), 64'd1);
            chk("restart_desc_left", 64'(exp_desc.size()), 64'd0);
            chk("restart_ar_left", 64'(exp_ar.size()), 64'd0);
            drop_en();

            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      join_any
   end
endmodule

// File: doc/dma_desc_fetch.md
Name: dma_desc_fetch

Overview:
- AXI read master that walks a linked list of DMA descriptors in memory.
- For each descriptor it reads one 5-word burst and writes each word into the DMA descriptor register block, one field per cycle, on the DESC_* write interface.
- It then pulses engine start, waits for the engine Done, and either follows NEXT_DESC or finishes the chain when EOC is set.
- Sits between the AXI interconnect (as a master) and the DMA register block.

Parameters:
ADDR_W, 32, address width (ARADDR, DESC_BASE, internal descriptor pointer)
DATA_W, 32, data width (RDATA, DESC_input)
ID_W, 4, AXI ID width
MST_ID, 0, constant ARID value driven on every read

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
DMAEN  in  1  chain enable; level
DESC_BASE  in  ADDR_W  address of first descriptor
Done  in  1  engine completion pulse
ARID  out  ID_W  =MST_ID
ARADDR  out  ADDR_W  burst start address
ARLEN  out  8  constant 4 (5 beats)
ARSIZE  out  3  constant 3'b010
ARBURST  out  2  constant 2'b01 (INCR)
ARVALID  out  1  address valid
ARREADY  in  1  address accepted
RID  in  ID_W  ignored
RDATA  in  DATA_W  read data
RRESP  in  2  read response
RLAST  in  1  last beat
RVALID  in  1  data valid
RREADY  out  1  data accept
DESC_input  out  DATA_W  field value
DESC_sel  out  4  0:SRC 1:DST 2:LEN 3:NEXT_DESC 4:EOC
DESC_write_en  out  1  one-cycle field write strobe
engine_start  out  1  one-cycle start pulse
busy  out  1  high in every state except IDLE
chain_done  out  1  one-cycle pulse on FINISH entry
err  out  1  sticky bus/protocol error flag

Behaviour:
- Reset values: all outputs 0, including ARVALID, RREADY, DESC_*, engine_start, chain_done, err and busy. State=IDLE, ptr=0, beat=0.
- States: IDLE, AR, RD, START, WAIT, FINISH, ERR.
- IDLE: when DMAEN=1, ptr <= {DESC_BASE[ADDR_W-1:5], 5'b0}, so descriptors are 32-byte aligned and a burst never crosses 4KB. Next state AR.
- AR: ARVALID=1 and ARADDR=ptr, held stable until ARREADY. On the handshake: ARVALID drops the next cycle, beat <= 0, next state RD.
- RD: RREADY=1. Per accepted beat (RVALID&RREADY):
  - Registered outputs: DESC_write_en=1, DESC_sel=beat, DESC_input=RDATA, valid in the following cycle only.
  - beat 3: latch next_ptr = RDATA aligned as above.
  - beat 4: latch eoc = RDATA[0].
  - beat increments.
- RD exit:
  - RLAST with beat==4 and no error -> START.
  - RRESP!=0 on any beat, RLAST with beat<4, or beat==4 without RLAST: set err. That beat and all later beats get no DESC write.
  - After an error, keep RREADY=1 until RLAST is accepted, then go to ERR.
- START: entered the cycle the beat-4 DESC write is presented. Wait one more cycle so the register block has latched it, then pulse engine_start for exactly one cycle -> WAIT.
- WAIT:
  - Done=1 and eoc=1 -> FINISH.
  - Done=1 and eoc=0 -> ptr <= next_ptr, go to AR. The next ARVALID rises the cycle after Done.
  - Done arriving in the same cycle as engine_start is not possible. Done sampled outside WAIT is ignored.
- FINISH: chain_done pulses one cycle on entry. Stay in FINISH while DMAEN=1, so there is no auto-restart. Go to IDLE when DMAEN=0.
- ERR: err=1. Stay while DMAEN=1. When DMAEN=0, go to IDLE; err clears on the IDLE entry.
- DMAEN is sampled only in IDLE, FINISH and ERR. Deassertion mid-chain is ignored, because an in-flight burst cannot be abandoned.
- rst at any time: immediate return to reset values. The interconnect must be reset concurrently.
- NEXT_DESC == current ptr (self-loop) is legal; it refetches forever until EOC.

Test Plan:
1. Single descriptor: DESC_BASE=0x1000, memory words {0x2000, 0x3000, 0x40, 0x0, 0x1}, DMAEN=1, ARREADY immediate -> ARADDR=0x1000, ARLEN=4, five DESC writes sel 0..4 with those values on consecutive cycles, one engine_start; after Done, chain_done pulses and busy stays high until DMAEN=0.
2. Two-link chain: descriptor at 0x1000 has NEXT=0x1020 and EOC=0; descriptor at 0x1020 has EOC=1 -> second AR at 0x1020 the cycle after the first Done, two engine_start pulses, a single chain_done.
3. Backpressure: ARREADY delayed 3 cycles and RVALID gaps of 2 cycles between beats -> ARADDR stable while ARVALID=1, DESC writes only for accepted beats, correct sel order.
4. Error: RRESP=2'b10 on beat 2 -> DESC writes for sel 0 and 1 only, RREADY held through RLAST, err=1, no engine_start; DMAEN=0 -> IDLE and err=0.
5. Unaligned base 0x1014 -> ARADDR=0x1000. Spurious Done in IDLE -> no state change.
6. Assert rst during RD beat 2 -> all outputs 0 next edge; after release with DMAEN=1 the fetch restarts at DESC_BASE.
